// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: responder for the CPU core's SRAM-style instruction and
// data ports. Each core request becomes one single-beat AXI transaction,
// with one transaction outstanding at a time and data requests given
// priority over instruction fetches. The per-port stall outputs hold the
// core's FI/ME stages until their access has completed.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ARID = 4'd0,
    parameter logic [3:0] DATA_ID   = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    // Instruction port
    input  logic        inst_en,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_stall,

    // Data port
    input  logic        data_en,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_stall,

    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    // AXI read data channel (rresp is not used)
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    // AXI write address channel
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    // AXI write data channel
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    // AXI write response channel (bresp is not used)
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D_AR = 3'd1,
        D_R  = 3'd2,
        D_WR = 3'd3,
        D_B  = 3'd4,
        I_AR = 3'd5,
        I_R  = 3'd6
    } state_t;

    state_t      state;
    state_t      state_next;

    // Request captured when leaving IDLE; held stable for the whole transaction
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wen;

    // Completion flags: a set flag means that port's access is finished and
    // must not be reissued until the whole pipeline advances.
    logic        inst_done;
    logic        data_done;

    // Per-channel handshake tracking for the write address/data pair
    logic        aw_done;
    logic        w_done;

    logic        advance;

    // Store size from the byte-enable pattern; unexpected patterns fall back to a word
    function automatic logic [2:0] size_from_wen(input logic [3:0] wen);
        logic [2:0] size;
        case (wen)
            4'b1111:                            size = 3'd2;
            4'b0011, 4'b1100:                   size = 3'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 3'd0;
            default:                            size = 3'd2;
        endcase
        return size;
    endfunction

    assign inst_stall = inst_en & ~inst_done;
    assign data_stall = data_en & ~data_done;
    assign advance    = ~inst_stall & ~data_stall;

    // Payload comes only from the latched request, so it cannot change under a pending valid
    assign araddr  = {req_addr[31:2], 2'b00};
    assign awaddr  = {req_addr[31:2], 2'b00};
    assign arsize  = 3'd2;
    assign awsize  = size_from_wen(req_wen);
    assign awid    = DATA_ID;
    assign wid     = DATA_ID;
    assign wdata   = req_wdata;
    assign wstrb   = req_wen;

    // Single-beat INCR, normal access, everything else zero
    assign arlen   = 4'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awlen   = 4'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wlast   = 1'b1;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: data before instruction, one request per pass
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (data_stall && (data_wen != 4'b0000)) begin
                    state_next = D_WR;
                end else if (data_stall) begin
                    state_next = D_AR;
                end else if (inst_stall) begin
                    state_next = I_AR;
                end
            end
            D_AR: if (arready) state_next = D_R;
            D_R:  if (rvalid)  state_next = IDLE;
            D_WR: begin
                if ((aw_done || awready) && (w_done || wready)) begin
                    state_next = D_B;
                end
            end
            D_B:  if (bvalid)  state_next = IDLE;
            I_AR: if (arready) state_next = I_R;
            I_R:  if (rvalid)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Channel handshake outputs decoded from the current state
    always_comb begin
        arvalid = 1'b0;
        arid    = DATA_ID;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (state)
            D_AR: arvalid = 1'b1;
            D_R:  rready  = 1'b1;
            D_WR: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
            end
            D_B:  bready  = 1'b1;
            I_AR: begin
                arvalid = 1'b1;
                arid    = INST_ARID;
            end
            I_R:  rready  = 1'b1;
            default: ;
        endcase
    end

    // Capture the request being served as the FSM leaves IDLE
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (data_stall) begin
                req_addr  <= data_addr;
                req_wdata <= data_wdata;
                req_wen   <= data_wen;
            end else if (inst_stall) begin
                req_addr  <= inst_addr;
                req_wen   <= 4'b0000;
            end
        end
    end

    // Completion flags, returned read data and write-channel handshake tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            inst_rdata <= 32'd0;
            data_rdata <= 32'd0;
        end else begin
            // Flags only clear once both ports stop stalling, so a finished
            // access survives while the other port keeps the pipeline frozen.
            if (advance) begin
                inst_done <= 1'b0;
                data_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                D_R: begin
                    if (rvalid) begin
                        data_rdata <= rdata;
                        data_done  <= 1'b1;
                    end
                end
                D_WR: begin
                    if (awready) aw_done <= 1'b1;
                    if (wready)  w_done  <= 1'b1;
                end
                D_B: begin
                    if (bvalid) data_done <= 1'b1;
                end
                I_R: begin
                    if (rvalid) begin
                        inst_rdata <= rdata;
                        inst_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed testbench for sram_axi_bridge. Inputs change 1ns after each rising
// edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_stall;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_stall;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int errors = 0;
    int checks = 0;

    sram_axi_bridge #(.INST_ARID(4'd0), .DATA_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
        .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_stall(data_stall),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // Move to the input-drive point just after the next rising edge
    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point on the falling edge
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_en = 1'b1; inst_addr = 32'd0;
        data_en = 1'b1; data_wen = 4'd0; data_addr = 32'd0; data_wdata = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        drv(); drv();
        smp();
        checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin errors++; $display("FAIL reset_valids got %b exp 00000", {arvalid, awvalid, wvalid, rready, bready}); end
        checks++; if (inst_rdata !== 32'd0) begin errors++; $display("FAIL reset_inst_rdata got %h exp 00000000", inst_rdata); end
        checks++; if (data_rdata !== 32'd0) begin errors++; $display("FAIL reset_data_rdata got %h exp 00000000", data_rdata); end
        checks++; if ({inst_stall, data_stall} !== 2'b11) begin errors++; $display("FAIL reset_done_flags stalls got %b exp 11", {inst_stall, data_stall}); end
        checks++; if ({arlen, arburst, awlen, awburst, wlast, wid} !== {4'd0, 2'b01, 4'd0, 2'b01, 1'b1, 4'd1}) begin errors++; $display("FAIL tieoffs got %h exp %h", {arlen, arburst, awlen, awburst, wlast, wid}, {4'd0, 2'b01, 4'd0, 2'b01, 1'b1, 4'd1}); end
        inst_en = 1'b0; data_en = 1'b0;
        drv();
        rst = 1'b0;
        drv();
        smp();
        checks++; if ({inst_stall, data_stall, arvalid} !== 3'b000) begin errors++; $display("FAIL reset_idle got %b exp 000", {inst_stall, data_stall, arvalid}); end
    endtask

    task automatic test_fetch();
        drv(); inst_en = 1'b1; inst_addr = 32'hBFC00000;
        smp();
        checks++; if ({inst_stall, arvalid} !== 2'b10) begin errors++; $display("FAIL fetch_req got %b exp 10", {inst_stall, arvalid}); end
        drv(); arready = 1'b1;
        smp();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'hBFC00000) begin errors++; $display("FAIL fetch_ar got v=%b a=%h exp v=1 a=bfc00000", arvalid, araddr); end
        checks++; if (arid !== 4'd0 || arsize !== 3'd2 || rready !== 1'b0) begin errors++; $display("FAIL fetch_ar_attr got id=%h sz=%h rr=%b exp id=0 sz=2 rr=0", arid, arsize, rready); end
        drv(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h3C088000;
        smp();
        checks++; if ({rready, arvalid, inst_stall} !== 3'b101) begin errors++; $display("FAIL fetch_r got %b exp 101", {rready, arvalid, inst_stall}); end
        drv(); rvalid = 1'b0; rdata = 32'd0;
        smp();
        checks++; if (inst_stall !== 1'b0 || inst_rdata !== 32'h3C088000) begin errors++; $display("FAIL fetch_done got st=%b d=%h exp st=0 d=3c088000", inst_stall, inst_rdata); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL fetch_no_reissue got arvalid=%b exp 0", arvalid); end
        // Pipeline advances on this edge; core presents the next fetch
        drv(); inst_addr = 32'hBFC00004;
        smp();
        checks++; if ({inst_stall, arvalid} !== 2'b10) begin errors++; $display("FAIL fetch2_req got %b exp 10", {inst_stall, arvalid}); end
        drv(); arready = 1'b1;
        smp();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'hBFC00004) begin errors++; $display("FAIL fetch2_ar got v=%b a=%h exp v=1 a=bfc00004", arvalid, araddr); end
        drv(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h11111111;
        drv(); rvalid = 1'b0;
        smp();
        checks++; if (inst_stall !== 1'b0 || inst_rdata !== 32'h11111111) begin errors++; $display("FAIL fetch2_done got st=%b d=%h exp st=0 d=11111111", inst_stall, inst_rdata); end
        drv(); inst_en = 1'b0;
        drv();
    endtask

    task automatic test_store_half();
        drv(); data_en = 1'b1; data_wen = 4'b0011; data_addr = 32'h00000102; data_wdata = 32'h0000BEEF;
        smp();
        checks++; if (data_stall !== 1'b1) begin errors++; $display("FAIL st_req got stall=%b exp 1", data_stall); end
        drv(); awready = 1'b1;
        smp();
        checks++; if ({awvalid, wvalid, bready} !== 3'b110) begin errors++; $display("FAIL st_valids got %b exp 110", {awvalid, wvalid, bready}); end
        checks++; if (awaddr !== 32'h00000100 || awsize !== 3'd1 || wstrb !== 4'b0011) begin errors++; $display("FAIL st_aw got a=%h sz=%h sb=%b exp a=00000100 sz=1 sb=0011", awaddr, awsize, wstrb); end
        checks++; if (wdata !== 32'h0000BEEF || awid !== 4'd1) begin errors++; $display("FAIL st_w got d=%h id=%h exp d=0000beef id=1", wdata, awid); end
        drv(); awready = 1'b0;
        smp();
        checks++; if ({awvalid, wvalid, bready} !== 3'b010) begin errors++; $display("FAIL st_aw_taken got %b exp 010", {awvalid, wvalid, bready}); end
        drv(); wready = 1'b1;
        smp();
        checks++; if ({awvalid, wvalid, bready} !== 3'b010) begin errors++; $display("FAIL st_w_wait got %b exp 010", {awvalid, wvalid, bready}); end
        drv(); wready = 1'b0;
        smp();
        checks++; if ({awvalid, wvalid, bready, data_stall} !== 4'b0011) begin errors++; $display("FAIL st_b got %b exp 0011", {awvalid, wvalid, bready, data_stall}); end
        drv(); bvalid = 1'b1;
        drv(); bvalid = 1'b0;
        smp();
        checks++; if ({data_stall, awvalid, bready} !== 3'b000) begin errors++; $display("FAIL st_done got %b exp 000", {data_stall, awvalid, bready}); end
        drv(); data_en = 1'b0; data_wen = 4'b0000;
        drv();
    endtask

    task automatic test_fetch_and_load();
        drv();
        inst_en = 1'b1; inst_addr = 32'h00400000;
        data_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h10000008;
        smp();
        checks++; if ({inst_stall, data_stall} !== 2'b11) begin errors++; $display("FAIL both_req got %b exp 11", {inst_stall, data_stall}); end
        drv(); arready = 1'b1;
        smp();
        checks++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h10000008) begin errors++; $display("FAIL both_data_ar got v=%b id=%h a=%h exp v=1 id=1 a=10000008", arvalid, arid, araddr); end
        drv(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFEF00D;
        drv(); rvalid = 1'b0;
        smp();
        checks++; if ({data_stall, inst_stall, arvalid} !== 3'b010 || data_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL both_data_done got %b d=%h exp 010 d=cafef00d", {data_stall, inst_stall, arvalid}, data_rdata); end
        drv(); arready = 1'b1;
        smp();
        checks++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h00400000) begin errors++; $display("FAIL both_inst_ar got v=%b id=%h a=%h exp v=1 id=0 a=00400000", arvalid, arid, araddr); end
        checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL both_data_hold got stall=%b exp 0", data_stall); end
        drv(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h24020001;
        smp();
        checks++; if ({rready, arvalid} !== 2'b10) begin errors++; $display("FAIL both_inst_r got %b exp 10", {rready, arvalid}); end
        drv(); rvalid = 1'b0;
        smp();
        checks++; if ({inst_stall, data_stall, arvalid} !== 3'b000 || inst_rdata !== 32'h24020001) begin errors++; $display("FAIL both_done got %b d=%h exp 000 d=24020001", {inst_stall, data_stall, arvalid}, inst_rdata); end
        drv(); inst_en = 1'b0; data_en = 1'b0;
        drv();
    endtask

    task automatic test_backpressure();
        drv(); data_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h20000010;
        for (int i = 0; i < 5; i++) begin
            drv();
            smp();
            checks++; if (arvalid !== 1'b1 || araddr !== 32'h20000010 || rready !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got v=%b a=%h rr=%b exp v=1 a=20000010 rr=0", i, arvalid, araddr, rready); end
        end
        drv(); arready = 1'b1;
        drv(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h5A5AA5A5;
        drv(); rvalid = 1'b0;
        smp();
        checks++; if (data_stall !== 1'b0 || data_rdata !== 32'h5A5AA5A5) begin errors++; $display("FAIL bp_done got st=%b d=%h exp st=0 d=5a5aa5a5", data_stall, data_rdata); end
        drv(); data_en = 1'b0;
        drv();
    endtask

    task automatic test_reset_mid();
        drv(); data_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h30000000;
        drv(); arready = 1'b1;
        drv(); arready = 1'b0;
        smp();
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_r got rready=%b exp 1", rready); end
        drv(); rst = 1'b1;
        smp();
        checks++; if ({rready, arvalid, awvalid, wvalid, bready} !== 5'b0) begin errors++; $display("FAIL rst_mid_valids got %b exp 00000", {rready, arvalid, awvalid, wvalid, bready}); end
        checks++; if (data_stall !== 1'b1 || data_rdata !== 32'd0 || inst_rdata !== 32'd0) begin errors++; $display("FAIL rst_mid_state got st=%b d=%h i=%h exp st=1 d=0 i=0", data_stall, data_rdata, inst_rdata); end
        drv(); rst = 1'b0; data_en = 1'b0;
        drv();
        smp();
        checks++; if ({arvalid, rready, data_stall} !== 3'b000) begin errors++; $display("FAIL rst_mid_after got %b exp 000", {arvalid, rready, data_stall}); end
    endtask

    task automatic test_byte_store_and_load();
        drv(); data_en = 1'b1; data_wen = 4'b1000; data_addr = 32'h40000003; data_wdata = 32'hAB000000;
        drv(); awready = 1'b1; wready = 1'b1;
        smp();
        checks++; if (awsize !== 3'd0 || wstrb !== 4'b1000 || awaddr !== 32'h40000000 || wdata !== 32'hAB000000) begin errors++; $display("FAIL byte_aw got sz=%h sb=%b a=%h d=%h exp sz=0 sb=1000 a=40000000 d=ab000000", awsize, wstrb, awaddr, wdata); end
        drv(); awready = 1'b0; wready = 1'b0;
        smp();
        checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL byte_b got %b exp 001", {awvalid, wvalid, bready}); end
        drv(); bvalid = 1'b1;
        drv(); bvalid = 1'b0;
        smp();
        checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL byte_done got stall=%b exp 0", data_stall); end
        drv(); data_en = 1'b0; data_wen = 4'b0000;
        drv(); data_en = 1'b1; data_addr = 32'h1FAF0004;
        drv(); arready = 1'b1;
        smp();
        checks++; if (arvalid !== 1'b1 || arsize !== 3'd2 || araddr !== 32'h1FAF0004 || arid !== 4'd1) begin errors++; $display("FAIL load_ar got v=%b sz=%h a=%h id=%h exp v=1 sz=2 a=1faf0004 id=1", arvalid, arsize, araddr, arid); end
        drv(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEADBEEF;
        drv(); rvalid = 1'b0;
        smp();
        checks++; if (data_stall !== 1'b0 || data_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_done got st=%b d=%h exp st=0 d=deadbeef", data_stall, data_rdata); end
        drv(); data_en = 1'b0;
        drv();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_half();
        test_fetch_and_load();
        test_backpressure();
        test_reset_mid();
        test_byte_store_and_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
